// File: rtl/cnn_pool_pkg.sv
// Shared constants and FSM state type for the binarized-box pooling stage.
package cnn_pool_pkg;

  localparam int unsigned BOX_SIZE = 280;
  localparam int unsigned OUT_DIM  = 28;
  localparam int unsigned CELL     = 10;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CNT_W    = 7;
  // Counter widths: pixel-in-cell (0..CELL-1) and cell index (0..OUT_DIM-1).
  localparam int unsigned SX_W     = 4;
  localparam int unsigned CX_W     = 5;

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} pool_state_e;

endpackage

// File: rtl/pool_acc_bank.sv
// Per-column foreground counters for the current cell row: one read-add(-clear) per cycle
// on a single index, plus a synchronous clear of the whole bank.
module pool_acc_bank #(
  parameter int unsigned Depth = 28,
  parameter int unsigned CntW  = 7,
  parameter int unsigned IdxW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_all,
  input  logic            en,
  input  logic [IdxW-1:0] idx,
  input  logic            inc,
  input  logic            clr,
  output logic [CntW-1:0] sum
);

  logic [CntW-1:0] acc_q [Depth];

  // Sum includes the current pixel so the cell result is available in the same cycle.
  assign sum = acc_q[idx] + CntW'(inc);

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int i = 0; i < int'(Depth); i++) begin
        acc_q[i] <= '0;
      end
    end else if (en) begin
      acc_q[idx] <= clr ? '0 : sum;
    end
  end

endmodule

// File: rtl/bin_box_pool.sv
// Pools the binarized selection box into an OUT_DIM x OUT_DIM bitmap of thresholded cell
// counts, streams the cell results into the CNN buffer and holds the frame until acked.
module bin_box_pool
  import cnn_pool_pkg::*;
#(
  parameter int unsigned BOX_SIZE   = cnn_pool_pkg::BOX_SIZE,
  parameter int unsigned OUT_DIM    = cnn_pool_pkg::OUT_DIM,
  parameter int unsigned CELL       = cnn_pool_pkg::CELL,
  parameter int unsigned CNT_THRESH = 50,
  parameter logic        FG_POL     = 1'b1
) (
  input  logic              cam_pclk,
  input  logic              rst,
  input  logic              in_vsync,
  input  logic              in_valid,
  input  logic              in_gray_en,
  input  logic              in_bin,
  input  logic              frame_ack,
  output logic              pool_wr_en,
  output logic [ADDR_W-1:0] pool_wr_addr,
  output logic              pool_wr_bit,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  // Cells per box row; equals OUT_DIM for any legal configuration.
  localparam int unsigned CellsX = BOX_SIZE / CELL;

  pool_state_e state_q, state_d;
  logic vsync_q;
  logic [SX_W-1:0] sx_q, sy_q;
  logic [CX_W-1:0] cx_q, cy_q;
  logic qual, fg, vs_rise, arm_clear, abort, accept;
  logic sx_wrap, sy_wrap, cx_wrap, cy_wrap, cell_last, frame_last;
  logic [CNT_W-1:0] acc_sum;
  logic [ADDR_W-1:0] cy_ext, cell_addr;
  logic [ADDR_W-1:0] wr_addr_q;
  logic wr_en_q, wr_bit_q, done_q, err_q;

  assign qual      = in_valid & in_gray_en;
  assign fg        = (in_bin == FG_POL);
  assign vs_rise   = in_vsync & ~vsync_q;
  // DONE ignores vsync so an unacknowledged bitmap is never overwritten.
  assign arm_clear = vs_rise & (state_q != StDone);
  assign abort     = vs_rise & (state_q == StRun);
  assign accept    = qual & ~vs_rise & busy;

  assign sx_wrap    = (sx_q == SX_W'(CELL - 1));
  assign sy_wrap    = (sy_q == SX_W'(CELL - 1));
  assign cx_wrap    = (cx_q == CX_W'(CellsX - 1));
  assign cy_wrap    = (cy_q == CX_W'(OUT_DIM - 1));
  assign cell_last  = accept & sx_wrap & sy_wrap;
  assign frame_last = cell_last & cx_wrap & cy_wrap;

  // cy*28 + cx without a multiplier.
  assign cy_ext    = ADDR_W'(cy_q);
  assign cell_addr = (cy_ext << 4) + (cy_ext << 3) + (cy_ext << 2) + ADDR_W'(cx_q);

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state_q <= StIdle;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= in_vsync;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (vs_rise) state_d = StArm;
      StArm:  if (!vs_rise && qual) state_d = StRun;
      StRun: begin
        if (vs_rise) state_d = StArm;
        else if (frame_last) state_d = StDone;
      end
      StDone: if (frame_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StArm) || (state_q == StRun);
    pool_wr_en   = wr_en_q;
    pool_wr_addr = wr_addr_q;
    pool_wr_bit  = wr_bit_q;
    frame_done   = done_q;
    frame_err    = err_q;
  end

  always_ff @(posedge cam_pclk) begin
    if (rst || arm_clear) begin
      sx_q <= '0;
      sy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else if (accept) begin
      sx_q <= sx_wrap ? '0 : sx_q + SX_W'(1);
      if (sx_wrap) begin
        cx_q <= cx_wrap ? '0 : cx_q + CX_W'(1);
        if (cx_wrap) begin
          sy_q <= sy_wrap ? '0 : sy_q + SX_W'(1);
          if (sy_wrap) cy_q <= cy_wrap ? '0 : cy_q + CX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_bit_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= cell_last;
      if (cell_last) begin
        wr_addr_q <= cell_addr;
        wr_bit_q  <= (acc_sum >= CNT_W'(CNT_THRESH));
      end
      done_q <= (state_q == StDone) && !frame_ack;
      err_q  <= abort;
    end
  end

  pool_acc_bank #(
    .Depth(OUT_DIM),
    .CntW (CNT_W),
    .IdxW (CX_W)
  ) u_acc_bank (
    .clk    (cam_pclk),
    .rst    (rst),
    .clr_all(arm_clear),
    .en     (accept),
    .idx    (cx_q),
    .inc    (fg),
    .clr    (sx_wrap & sy_wrap),
    .sum    (acc_sum)
  );

endmodule

// File: tb/tb_bin_box_pool.sv
// Bench for bin_box_pool: drives random images through a reduced-cell instance and scores
// every bitmap write against cell counts computed directly from the image.
`timescale 1ns/1ps
module tb_bin_box_pool;

  localparam int OD  = 28;
  localparam int CL  = 3;
  localparam int BOX = OD * CL;
  localparam int THR = 5;
  localparam int NPX = BOX * BOX;

  logic       cam_pclk = 1'b0;
  logic       rst, in_vsync, in_valid, in_gray_en, in_bin, frame_ack;
  logic       pool_wr_en, pool_wr_bit, frame_done, frame_err, busy;
  logic [9:0] pool_wr_addr;

  bin_box_pool #(
    .BOX_SIZE  (BOX),
    .OUT_DIM   (OD),
    .CELL      (CL),
    .CNT_THRESH(THR),
    .FG_POL    (1'b1)
  ) dut (
    .cam_pclk    (cam_pclk),
    .rst         (rst),
    .in_vsync    (in_vsync),
    .in_valid    (in_valid),
    .in_gray_en  (in_gray_en),
    .in_bin      (in_bin),
    .frame_ack   (frame_ack),
    .pool_wr_en  (pool_wr_en),
    .pool_wr_addr(pool_wr_addr),
    .pool_wr_bit (pool_wr_bit),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 cam_pclk = ~cam_pclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  // Monitor: log writes, frame_err pulses and frame_done rises, sampled on the falling edge.
  int   wr_addr_log[$];
  bit   wr_bit_log[$];
  int   wr_cyc_log[$];
  int   err_cnt = 0;
  int   err_cyc = -1;
  int   done_rise_cyc = -1;
  logic done_prev = 1'b0;
  always @(negedge cam_pclk) begin
    if (pool_wr_en === 1'b1) begin
      wr_addr_log.push_back(int'(pool_wr_addr));
      wr_bit_log.push_back(pool_wr_bit);
      wr_cyc_log.push_back(cyc);
    end
    if (frame_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (frame_done === 1'b1 && done_prev !== 1'b1) done_rise_cyc <= cyc;
    done_prev <= frame_done;
  end

  bit img [BOX][BOX];

  // Reference: a cell is 1 when at least THR of its CL*CL pixels are foreground.
  function automatic bit exp_bit(input int a);
    int cy = a / OD;
    int cx = a % OD;
    int cnt = 0;
    for (int y = 0; y < CL; y++)
      for (int x = 0; x < CL; x++)
        cnt += int'(img[cy * CL + y][cx * CL + x]);
    return cnt >= THR;
  endfunction

  function automatic int count_bad(input int base, output int first);
    int bad = 0;
    first = -1;
    for (int i = 0; i < OD * OD && base + i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[base + i] != i || wr_bit_log[base + i] != exp_bit(i)) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int count_ones(input int base);
    int n = 0;
    for (int i = base; i < wr_bit_log.size(); i++) n += int'(wr_bit_log[i]);
    return n;
  endfunction

  task automatic step();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_gray_en = 1'b0;
    in_bin     = 1'b0;
  endtask

  task automatic fill_img(input int mode, input int pct);
    for (int y = 0; y < BOX; y++)
      for (int x = 0; x < BOX; x++)
        case (mode)
          0:       img[y][x] = 1'b1;
          1:       img[y][x] = (x < BOX / 2);
          default: img[y][x] = (int'($urandom_range(99)) < pct);
        endcase
  endtask

  // k returns the cycle index of the clock edge that sampled the vsync rise.
  task automatic pulse_vsync(input bit with_px, output int k);
    in_vsync = 1'b0;
    step();
    in_vsync   = 1'b1;
    in_valid   = with_px;
    in_gray_en = with_px;
    in_bin     = 1'b1;
    step();
    k = cyc;
    in_vsync = 1'b0;
    idle_inputs();
  endtask

  // k returns the cycle index of the edge that sampled the last pixel.
  task automatic send_pixels(input int first, input int last, input int bubble_pct,
                             output int k);
    for (int i = first; i <= last; i++) begin
      while (int'($urandom_range(99)) < bubble_pct) begin
        case ($urandom_range(2))
          0:       begin in_valid = 1'b0; in_gray_en = 1'b0; end
          1:       begin in_valid = 1'b1; in_gray_en = 1'b0; end
          default: begin in_valid = 1'b0; in_gray_en = 1'b1; end
        endcase
        in_bin = 1'($urandom_range(1));
        step();
      end
      in_valid   = 1'b1;
      in_gray_en = 1'b1;
      in_bin     = img[i / BOX][i % BOX];
      step();
    end
    k = cyc;
    idle_inputs();
  endtask

  task automatic ack_frame(input string name);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ack: frame_done=%b busy=%b, expected 0 0", name, frame_done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vsync = 1'b0; frame_ack = 1'b0;
    idle_inputs();
    step();
    step();
    n_cmp++;
    if ({pool_wr_en, pool_wr_addr, pool_wr_bit, frame_done, frame_err, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: en=%b addr=%0d bit=%b done=%b err=%b busy=%b, expected all 0",
               pool_wr_en, pool_wr_addr, pool_wr_bit, frame_done, frame_err, busy);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int k, lk, base, e0;
    fill_img(0, 0);
    base = wr_addr_log.size();
    e0 = err_cnt;
    pulse_vsync(1'b0, k);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL arm_busy: busy=%b expected 1", busy);
    end
    // Pixel 3719 closes cell (14,7), i.e. the 400th write.
    send_pixels(0, 3719, 0, lk);
    step();
    step();
    n_cmp++;
    if (wr_addr_log.size() - base != 400) begin
      n_bad++;
      $display("FAIL abort_prefix_writes: got %0d expected 400", wr_addr_log.size() - base);
    end
    n_cmp++;
    if (wr_cyc_log[wr_cyc_log.size() - 1] != lk) begin
      n_bad++;
      $display("FAIL write_latency: write at cycle %0d expected %0d",
               wr_cyc_log[wr_cyc_log.size() - 1], lk);
    end
    pulse_vsync(1'b1, k);
    step();
    step();
    step();
    n_cmp++;
    if (err_cnt - e0 != 1 || err_cyc != k) begin
      n_bad++;
      $display("FAIL abort_err: pulses=%0d at cycle %0d, expected 1 at cycle %0d",
               err_cnt - e0, err_cyc, k);
    end
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b1 || wr_addr_log.size() - base != 400) begin
      n_bad++;
      $display("FAIL abort_state: done=%b busy=%b writes=%0d, expected 0 1 400",
               frame_done, busy, wr_addr_log.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    int k, lk, base, first, bad;
    fill_img(0, 0);
    base = wr_addr_log.size();
    pulse_vsync(1'b0, k);
    send_pixels(0, NPX - 1, 0, lk);
    step();
    step();
    step();
    bad = count_bad(base, first);
    n_cmp++;
    if (wr_addr_log.size() - base != OD * OD || bad != 0) begin
      n_bad++;
      $display("FAIL b2b_writes: count=%0d bad=%0d first_bad=%0d, expected %0d 0",
               wr_addr_log.size() - base, bad, first, OD * OD);
    end
    n_cmp++;
    if (wr_cyc_log[wr_cyc_log.size() - 1] != lk || done_rise_cyc != lk + 1) begin
      n_bad++;
      $display("FAIL b2b_done_timing: last_wr=%0d done_rise=%0d, expected %0d %0d",
               wr_cyc_log[wr_cyc_log.size() - 1], done_rise_cyc, lk, lk + 1);
    end
    n_cmp++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_level: done=%b busy=%b, expected 1 0", frame_done, busy);
    end
    ack_frame("b2b");
  endtask

  task automatic test_done_hold();
    int k, lk, base, first, bad;
    fill_img(1, 0);
    base = wr_addr_log.size();
    pulse_vsync(1'b0, k);
    send_pixels(0, NPX - 1, 5, lk);
    step();
    step();
    bad = count_bad(base, first);
    n_cmp++;
    if (wr_addr_log.size() - base != OD * OD || bad != 0) begin
      n_bad++;
      $display("FAIL left_half_writes: count=%0d bad=%0d first_bad=%0d, expected %0d 0",
               wr_addr_log.size() - base, bad, first, OD * OD);
    end
    n_cmp++;
    if (count_ones(base) != 14 * OD || done_rise_cyc != lk + 1) begin
      n_bad++;
      $display("FAIL left_half_ones: ones=%0d done_rise=%0d, expected %0d %0d",
               count_ones(base), done_rise_cyc, 14 * OD, lk + 1);
    end
    base = wr_addr_log.size();
    pulse_vsync(1'b0, k);
    send_pixels(0, 299, 0, lk);
    step();
    step();
    n_cmp++;
    if (wr_addr_log.size() != base || frame_done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_hold: writes=%0d done=%b busy=%b, expected 0 1 0",
               wr_addr_log.size() - base, frame_done, busy);
    end
    // Ack and a vsync rise together: the rise is lost.
    frame_ack = 1'b1;
    in_vsync  = 1'b1;
    step();
    frame_ack = 1'b0;
    in_vsync  = 1'b0;
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_vs_vsync: done=%b busy=%b, expected 0 0", frame_done, busy);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_vs_vsync_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_threshold();
    int k, lk, base, first, bad;
    fill_img(2, 50);
    for (int p = 0; p < CL * CL; p++) begin
      img[p / CL][p % CL]      = (p < THR - 1);
      img[p / CL][CL + p % CL] = (p < THR);
    end
    base = wr_addr_log.size();
    pulse_vsync(1'b0, k);
    send_pixels(0, NPX - 1, 15, lk);
    step();
    step();
    bad = count_bad(base, first);
    n_cmp++;
    if (wr_addr_log.size() - base != OD * OD || bad != 0) begin
      n_bad++;
      $display("FAIL thresh_writes: count=%0d bad=%0d first_bad=%0d, expected %0d 0",
               wr_addr_log.size() - base, bad, first, OD * OD);
    end
    n_cmp++;
    if (wr_bit_log[base] !== 1'b0 || wr_bit_log[base + 1] !== 1'b1) begin
      n_bad++;
      $display("FAIL thresh_boundary: cell0=%b cell1=%b, expected 0 1",
               wr_bit_log[base], wr_bit_log[base + 1]);
    end
    ack_frame("thresh");
  endtask

  task automatic test_reset_mid_run();
    int k, lk, base, e0;
    fill_img(2, 60);
    pulse_vsync(1'b0, k);
    send_pixels(0, 169, 0, lk);
    // Pixel 170 closes cell (0,0) but arrives together with reset.
    base = wr_addr_log.size();
    e0 = err_cnt;
    in_valid = 1'b1; in_gray_en = 1'b1; in_bin = img[2][2];
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    n_cmp++;
    if ({pool_wr_en, pool_wr_addr, pool_wr_bit, frame_done, frame_err, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: en=%b addr=%0d bit=%b done=%b err=%b busy=%b, expected all 0",
               pool_wr_en, pool_wr_addr, pool_wr_bit, frame_done, frame_err, busy);
    end
    send_pixels(171, 700, 0, lk);
    step();
    step();
    n_cmp++;
    if (wr_addr_log.size() != base || err_cnt != e0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_quiet: writes=%0d errs=%0d busy=%b, expected 0 0 0",
               wr_addr_log.size() - base, err_cnt - e0, busy);
    end
  endtask

  task automatic test_random();
    int k, lk, base, first, bad;
    fill_img(2, int'($urandom_range(35, 65)));
    base = wr_addr_log.size();
    pulse_vsync(1'b0, k);
    send_pixels(0, NPX - 1, 25, lk);
    step();
    step();
    bad = count_bad(base, first);
    n_cmp++;
    if (wr_addr_log.size() - base != OD * OD || bad != 0) begin
      n_bad++;
      $display("FAIL random_writes: count=%0d bad=%0d first_bad=%0d, expected %0d 0",
               wr_addr_log.size() - base, bad, first, OD * OD);
    end
    n_cmp++;
    if (done_rise_cyc != lk + 1 || frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL random_done: done_rise=%0d level=%b, expected %0d 1",
               done_rise_cyc, frame_done, lk + 1);
    end
    ack_frame("random");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_abort();
    test_back_to_back();
    test_done_hold();
    test_threshold();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
